m68k_bus_master: RTL and testbench

- Synchronous 68000-style bus initiator in the CPLD. It issues word/byte read and write cycles on the board's 68k bus from a simple request/response port.
- Used by the boot/debug path to load and inspect EEPROM and RAM while the CPU is held off the bus.
- Acts as the initiator side for the existing address decoder and DTACK/BERR responders. It drives AS/UDS/LDS/RW and samples DTACK_n/BERR_n.

---
 rtl/m68k_bus_pkg.sv | 20 ++
 rtl/m68k_sync.sv | 25 ++
 rtl/m68k_bus_master.sv | 201 ++++++++++++++++++++
 tb/tb_m68k_bus_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68k bus initiator.
// Covers the state encoding, data-strobe masks and the default timeout.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_END     = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    localparam logic [1:0] BE_WORD  = 2'b11;
    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_LOWER = 2'b01;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/m68k_sync.sv
// Multi-stage synchroniser for asynchronous active-low bus responses.
// Resets to 1 so that a released bus reads as "no response".
module m68k_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator driven by a request/response port.
// Define M68K_BUS_MASTER_RETRY_EN to retry BERR-terminated cycles.
module m68k_bus_master
    import m68k_bus_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [22:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [22:0] bus_addr,
    output logic        bus_rw,
    output logic        bus_as_n,
    output logic        bus_uds_n,
    output logic        bus_lds_n,
    output logic [15:0] bus_data_out,
    output logic        bus_data_oe,
    input  logic [15:0] bus_data_in,
    input  logic        dtack_n,
    input  logic        berr_n
);

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] cnt;
    logic        we_q;
    logic [1:0]  be_q;
    logic [22:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        be0_q;
    logic        ready_q;
    logic        dtack_s;
    logic        berr_s;
    logic        retry;
    logic        accept;

    m68k_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (
        .clk   (clk50),
        .rst_n (reset_n),
        .d     (dtack_n),
        .q     (dtack_s)
    );

    m68k_sync #(.STAGES(SYNC_STAGES)) u_sync_berr (
        .clk   (clk50),
        .rst_n (reset_n),
        .d     (berr_n),
        .q     (berr_s)
    );

    assign accept       = req_valid && req_ready;
    assign bus_addr     = addr_q;
    assign bus_data_out = wdata_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;

    // State register
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and bus/handshake outputs decoded from state
    always_comb begin
        state_n     = state;
        req_ready   = 1'b0;
        bus_as_n    = 1'b1;
        bus_uds_n   = 1'b1;
        bus_lds_n   = 1'b1;
        bus_rw      = 1'b1;
        bus_data_oe = 1'b0;
        rsp_valid   = be0_q;
        unique case (state)
            ST_IDLE: begin
                req_ready = ready_q;
                if (req_valid && ready_q && (|req_be)) begin
                    state_n = ST_SETUP;
                end
            end
            ST_SETUP: begin
                bus_rw      = ~we_q;
                bus_data_oe = we_q;
                if (cnt == SETUP_LAST) begin
                    state_n = ST_STROBE;
                end
            end
            ST_STROBE, ST_WAIT: begin
                bus_rw      = ~we_q;
                bus_data_oe = we_q;
                bus_as_n    = 1'b0;
                bus_uds_n   = ~(|(be_q & BE_UPPER));
                bus_lds_n   = ~(|(be_q & BE_LOWER));
                if (state == ST_STROBE) begin
                    state_n = ST_WAIT;
                end else if (!berr_s || !dtack_s || cnt == TO_LAST) begin
                    state_n = ST_END;
                end
            end
            ST_END: begin
                bus_rw      = ~we_q;
                bus_data_oe = we_q;
                rsp_valid   = ~retry;
                state_n     = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (dtack_s && berr_s) begin
                    state_n = retry ? ST_SETUP : ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Request latch, phase counter and response capture
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            be0_q   <= 1'b0;
            cnt     <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            be0_q   <= 1'b0;
            if (state_n != state) begin
                cnt <= '0;
            end else if (state == ST_SETUP || state == ST_WAIT) begin
                cnt <= cnt + 16'd1;
            end
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                be_q    <= req_be & BE_WORD;
                wdata_q <= req_wdata;
                err_q   <= ~(|req_be);
                be0_q   <= ~(|req_be);
            end
            if (state == ST_WAIT) begin
                if (!berr_s) begin
                    err_q <= 1'b1;
                end else if (!dtack_s) begin
                    if (!we_q) begin
                        rdata_q <= bus_data_in;
                    end
                end else if (cnt == TO_LAST) begin
                    err_q <= 1'b1;
                end
            end
            if (state == ST_RECOVER && state_n == ST_SETUP) begin
                err_q <= 1'b0;
            end
        end
    end

`ifdef M68K_BUS_MASTER_RETRY_EN
    logic       retry_q;
    logic [1:0] retry_cnt;

    // Re-run BERR-terminated cycles up to three times before reporting
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            retry_q   <= 1'b0;
            retry_cnt <= '0;
        end else if (accept) begin
            retry_q   <= 1'b0;
            retry_cnt <= '0;
        end else if (state == ST_WAIT && !berr_s && retry_cnt != 2'd3) begin
            retry_q   <= 1'b1;
            retry_cnt <= retry_cnt + 2'd1;
        end else if (state == ST_RECOVER && state_n == ST_SETUP) begin
            retry_q <= 1'b0;
        end
    end

    assign retry = retry_q;
`else
    assign retry = 1'b0;
`endif

endmodule

// File: tb/tb_m68k_bus_master.sv
// Randomised bench for m68k_bus_master with a behavioural slave.
// Expected results come from per-transaction rules, not RTL state.
module tb_m68k_bus_master;

    localparam int TO = 16;

    logic        clk50;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [22:0] req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [22:0] bus_addr;
    logic        bus_rw;
    logic        bus_as_n;
    logic        bus_uds_n;
    logic        bus_lds_n;
    logic [15:0] bus_data_out;
    logic        bus_data_oe;
    logic [15:0] bus_data_in;
    logic        dtack_n;
    logic        berr_n;

    m68k_bus_master #(
        .SETUP_CYCLES   (1),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk50        (clk50),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_be       (req_be),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .bus_addr     (bus_addr),
        .bus_rw       (bus_rw),
        .bus_as_n     (bus_as_n),
        .bus_uds_n    (bus_uds_n),
        .bus_lds_n    (bus_lds_n),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        .bus_data_in  (bus_data_in),
        .dtack_n      (dtack_n),
        .berr_n       (berr_n)
    );

    int n_chk = 0;
    int n_pass = 0;

    // slave behaviour: 0 dtack, 1 berr, 2 dtack+berr, 3 silent
    int          sl_kind = 0;
    int          sl_delay = 0;
    int          sl_cnt = 0;
    logic [15:0] sl_data = '0;

    logic        exp_we = 1'b0;
    logic [22:0] exp_addr = '0;
    logic [1:0]  exp_be = '0;
    logic [15:0] exp_wdata = '0;
    logic [15:0] rd_model = '0;

    int   as_pulses = 0;
    int   as_low = 0;
    int   strobe_bad = 0;
    logic prev_as = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk50 = 1'b0;
        forever #5 clk50 = ~clk50;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    assign bus_data_in = sl_data;

    // Slave: answer sl_delay cycles after AS falls, release when AS rises
    initial begin
        dtack_n = 1'b1;
        berr_n  = 1'b1;
        forever begin
            @(posedge clk50);
            #1;
            if (!reset_n || bus_as_n) begin
                dtack_n = 1'b1;
                berr_n  = 1'b1;
                sl_cnt  = 0;
            end else begin
                if (sl_cnt >= sl_delay) begin
                    if (sl_kind == 0 || sl_kind == 2) dtack_n = 1'b0;
                    if (sl_kind == 1 || sl_kind == 2) berr_n = 1'b0;
                end
                sl_cnt++;
            end
        end
    end

    // Bus monitor: count AS pulses and check strobes while AS is low
    always @(negedge clk50) begin
        if (!bus_as_n) begin
            if (prev_as) begin
                as_pulses++;
                as_low = 0;
            end
            as_low++;
            if (bus_uds_n != ~exp_be[1] || bus_lds_n != ~exp_be[0] ||
                bus_rw != ~exp_we || bus_addr != exp_addr ||
                bus_data_oe != exp_we ||
                (exp_we && bus_data_out != exp_wdata)) begin
                strobe_bad++;
            end
        end
        prev_as = bus_as_n;
    end

    task automatic do_req(input string tag, input logic we,
                          input logic [22:0] addr, input logic [1:0] be,
                          input logic [15:0] wdata, input int kind,
                          input int dly, input logic [15:0] sdata);
        int   k;
        bit   got;
        bit   e_err;
        int   e_pulses;
        int   e_lat;
        sl_kind   = kind;
        sl_delay  = dly;
        sl_data   = sdata;
        exp_we    = we;
        exp_addr  = addr;
        exp_be    = be;
        exp_wdata = wdata;
        k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk50);
            k++;
        end
        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
        as_pulses  = 0;
        as_low     = 0;
        strobe_bad = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_be     = be;
        req_wdata  = wdata;
        got = 1'b0;
        for (k = 1; k <= 400; k++) begin
            @(negedge clk50);
            if (k == 1) req_valid = 1'b0;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "/rsp"}, 32'(got), 32'd1);
        if (got) begin
            e_lat = -1;
            if (be == 2'b00) begin
                e_err = 1'b1;
                e_pulses = 0;
                e_lat = 1;
            end else if (kind == 0) begin
                e_err = 1'b0;
                e_pulses = 1;
                e_lat = 5 + dly;
                if (!we) rd_model = sdata;
            end else if (kind == 3) begin
                e_err = 1'b1;
                e_pulses = 1;
            end else begin
                e_err = 1'b1;
`ifdef M68K_BUS_MASTER_RETRY_EN
                e_pulses = 4;
`else
                e_pulses = 1;
`endif
            end
            chk({tag, "/err"}, 32'(rsp_err), 32'(e_err));
            chk({tag, "/rdata"}, 32'(rsp_rdata), 32'(rd_model));
            chk({tag, "/as_pulses"}, 32'(as_pulses), 32'(e_pulses));
            chk({tag, "/strobes"}, 32'(strobe_bad), 32'd0);
            if (be != 2'b00) begin
                chk({tag, "/end_oe"}, 32'(bus_data_oe), 32'(we));
                chk({tag, "/end_as"}, 32'(bus_as_n), 32'd1);
            end
            if (e_lat >= 0) chk({tag, "/latency"}, 32'(k), 32'(e_lat));
            if (kind == 3 && be != 2'b00) begin
                chk({tag, "/as_low"}, 32'(as_low), 32'(TO + 1));
            end
            @(negedge clk50);
            chk({tag, "/pulse"}, 32'(rsp_valid), 32'd0);
            chk({tag, "/rel_oe"}, 32'(bus_data_oe), 32'd0);
            chk({tag, "/rel_as"}, 32'(bus_as_n), 32'd1);
        end
    endtask

    initial begin
        int r;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        #3;
        chk("rst/ready", 32'(req_ready), 32'd0);
        chk("rst/as", 32'(bus_as_n), 32'd1);
        chk("rst/uds", 32'(bus_uds_n), 32'd1);
        chk("rst/lds", 32'(bus_lds_n), 32'd1);
        chk("rst/rw", 32'(bus_rw), 32'd1);
        chk("rst/oe", 32'(bus_data_oe), 32'd0);
        chk("rst/addr", 32'(bus_addr), 32'd0);
        chk("rst/dout", 32'(bus_data_out), 32'd0);
        chk("rst/rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
        repeat (2) @(negedge clk50);
        reset_n = 1'b1;
        @(negedge clk50);
        chk("rst/ready_after", 32'(req_ready), 32'd1);

        do_req("word_rd", 1'b0, 23'h002000, 2'b11, 16'h0, 0, 3, 16'hBEEF);
        do_req("byte_wr", 1'b1, 23'h004000, 2'b01, 16'h00A5, 0, 0, 16'h1234);
        do_req("timeout", 1'b0, 23'h000100, 2'b11, 16'h0, 3, 0, 16'h5555);
        do_req("both", 1'b0, 23'h000200, 2'b10, 16'h0, 2, 1, 16'h7777);
        do_req("be0", 1'b1, 23'h000300, 2'b00, 16'hFFFF, 0, 0, 16'h0);

        // Asynchronous reset while a write waits for a silent slave
        sl_kind   = 3;
        exp_we    = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 23'h00ABCD;
        req_be    = 2'b11;
        req_wdata = 16'hC0DE;
        @(negedge clk50);
        req_valid = 1'b0;
        repeat (5) @(negedge clk50);
        chk("arst/pre_as", 32'(bus_as_n), 32'd0);
        chk("arst/pre_oe", 32'(bus_data_oe), 32'd1);
        @(posedge clk50);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst/as", 32'(bus_as_n), 32'd1);
        chk("arst/ds", 32'({bus_uds_n, bus_lds_n}), 32'd3);
        chk("arst/oe", 32'(bus_data_oe), 32'd0);
        chk("arst/ready", 32'(req_ready), 32'd0);
        #20;
        reset_n = 1'b1;
        rd_model = '0;
        @(negedge clk50);
        chk("arst/ready_pre_clk", 32'(req_ready), 32'd0);
        @(negedge clk50);
        chk("arst/ready", 32'(req_ready), 32'd1);
        chk("arst/idle_as", 32'(bus_as_n), 32'd1);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            do_req("rand", 1'($urandom), 23'($urandom), 2'($urandom),
                   16'($urandom),
                   (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3,
                   $urandom_range(0, 8), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
